// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the integer ALU, the result buffer and writeback arbitration.
`default_nettype none

interface alu_result_buffer_if #(
   parameter int XLEN          = 64,
   parameter int TRANS_ID_BITS = 3,
   parameter int DEPTH         = 2
);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic                     flush_i;
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [TRANS_ID_BITS-1:0] in_trans_id_i;
   logic [XLEN-1:0]          in_result_i;
   logic                     in_branch_res_i;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [TRANS_ID_BITS-1:0] out_trans_id_o;
   logic [XLEN-1:0]          out_result_o;
   logic                     out_branch_res_o;
   logic [c_CNT_W-1:0]       count_o;

   modport master (
      output flush_i, in_valid_i, in_trans_id_i, in_result_i, in_branch_res_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_trans_id_o, out_result_o, out_branch_res_o, count_o
   );

   modport slave (
      input  flush_i, in_valid_i, in_trans_id_i, in_result_i, in_branch_res_i, out_ready_i,
      output in_ready_o, out_valid_o, out_trans_id_o, out_result_o, out_branch_res_o, count_o
   );
endinterface

`default_nettype wire

// File: rtl/alu_result_buffer.sv
// ****************************************************************************
// * Module   : alu_result_buffer                                             *
// * Brief    : Registered ALU result FIFO with flush, ahead of writeback.    *
// *            Optional ALU_RESULT_BUFFER_BYPASS_EN: 0-cycle empty bypass.   *
// * Revision : 1.0 - initial release                                         *
// ****************************************************************************
`default_nettype none

module alu_result_buffer #(
   parameter int XLEN          = 64,
   parameter int TRANS_ID_BITS = 3,
   parameter int DEPTH         = 2
) (
   input  wire logic          clk_i,
   input  wire logic          rst_ni,
   alu_result_buffer_if.slave bus
);
   localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

   logic [XLEN-1:0]          r_result [DEPTH];
   logic [TRANS_ID_BITS-1:0] r_id     [DEPTH];
   logic [DEPTH-1:0]         r_br;
   logic [c_PTR_W-1:0]       r_wptr;
   logic [c_PTR_W-1:0]       r_rptr;
   logic [c_CNT_W-1:0]       r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_write;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);
   // Readiness is pure registered state: a full buffer refuses even with a same-cycle pop.
   assign w_push  = bus.in_valid_i && !w_full && !bus.flush_i;
   assign w_pop   = !w_empty && bus.out_ready_i && !bus.flush_i;

   assign bus.in_ready_o = !w_full;
   assign bus.count_o    = r_count;

`ifdef ALU_RESULT_BUFFER_BYPASS_EN
   logic w_bypass;

   assign w_bypass = w_empty && bus.in_valid_i && !bus.flush_i;
   // A bypassed result taken the same cycle never occupies storage.
   assign w_write  = w_push && !(w_bypass && bus.out_ready_i);

   assign bus.out_valid_o      = !w_empty || w_bypass;
   assign bus.out_trans_id_o   = w_bypass ? bus.in_trans_id_i   : r_id[r_rptr];
   assign bus.out_result_o     = w_bypass ? bus.in_result_i     : r_result[r_rptr];
   assign bus.out_branch_res_o = w_bypass ? bus.in_branch_res_i : r_br[r_rptr];
`else
   assign w_write = w_push;

   assign bus.out_valid_o      = !w_empty;
   assign bus.out_trans_id_o   = r_id[r_rptr];
   assign bus.out_result_o     = r_result[r_rptr];
   assign bus.out_branch_res_o = r_br[r_rptr];
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_br    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_result[i] <= '0;
            r_id[i]     <= '0;
         end
      end else if (bus.flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_write) begin
            r_result[r_wptr] <= bus.in_result_i;
            r_id[r_wptr]     <= bus.in_trans_id_i;
            r_br[r_wptr]     <= bus.in_branch_res_i;
            r_wptr           <= r_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_write) - c_CNT_W'(w_pop);
      end
   end

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_write && w_full));

   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_count <= c_FULL);

   a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rst_ni && bus.out_valid_o && !bus.out_ready_i && !bus.flush_i)
      |=> $stable({bus.out_trans_id_o, bus.out_result_o, bus.out_branch_res_o}));
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
// Randomised and directed bench for alu_result_buffer against a queue-based reference model.
`default_nettype none

module tb_alu_result_buffer;
   localparam int XLEN  = 64;
   localparam int TIDW  = 3;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [TIDW-1:0] id;
      logic [XLEN-1:0] res;
      logic            br;
   } ent_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   alu_result_buffer_if #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH)) bus ();

   alu_result_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int   total = 0;
   int   bad   = 0;
   bit   armed = 1'b0;
   ent_t q[$];
   ent_t exp_e;
   bit   exp_v;
   bit   m_pop, m_push, m_byp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Reference model: compare outputs mid-cycle, then advance the queue for the coming edge.
   always @(negedge clk_i) begin
      if (armed) begin
         exp_v = (q.size() != 0);
         exp_e = (q.size() != 0) ? q[0] : '0;
`ifdef ALU_RESULT_BUFFER_BYPASS_EN
         if (q.size() == 0 && bus.in_valid_i && !bus.flush_i) begin
            exp_v = 1'b1;
            exp_e = '{id: bus.in_trans_id_i, res: bus.in_result_i, br: bus.in_branch_res_i};
         end
`endif
         chk("m_count", 64'(bus.count_o), 64'(q.size()));
         chk("m_in_ready", 64'(bus.in_ready_o), 64'(q.size() != DEPTH));
         chk("m_out_valid", 64'(bus.out_valid_o), 64'(exp_v));
         if (exp_v) begin
            chk("m_out_id", 64'(bus.out_trans_id_o), 64'(exp_e.id));
            chk("m_out_result", bus.out_result_o, exp_e.res);
            chk("m_out_br", 64'(bus.out_branch_res_o), 64'(exp_e.br));
         end

         if (!rst_ni || bus.flush_i) begin
            q.delete();
         end else begin
            m_byp = 1'b0;
`ifdef ALU_RESULT_BUFFER_BYPASS_EN
            m_byp = (q.size() == 0) && bus.in_valid_i;
`endif
            m_pop  = (q.size() != 0) && bus.out_ready_i;
            m_push = bus.in_valid_i && (q.size() < DEPTH) && !(m_byp && bus.out_ready_i);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back('{id: bus.in_trans_id_i, res: bus.in_result_i, br: bus.in_branch_res_i});
         end
      end
   end

   task automatic push_one(input logic [TIDW-1:0] id, input logic [XLEN-1:0] res, input logic br);
      bus.in_valid_i      = 1'b1;
      bus.in_trans_id_i   = id;
      bus.in_result_i     = res;
      bus.in_branch_res_i = br;
      cyc();
      bus.in_valid_i = 1'b0;
   endtask

   logic [TIDW-1:0] popped[$];
   int              sent;
   bit              will_accept;

   initial begin
      bus.flush_i         = 1'b0;
      bus.in_valid_i      = 1'b0;
      bus.in_trans_id_i   = '0;
      bus.in_result_i     = '0;
      bus.in_branch_res_i = 1'b0;
      bus.out_ready_i     = 1'b0;

      // Reset then idle
      rst_ni = 1'b0;
      repeat (2) cyc();
      armed = 1'b1;
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      chk("rst_count", 64'(bus.count_o), 64'd0);
      chk("rst_result", bus.out_result_o, 64'd0);
      rst_ni = 1'b1;
      cyc();

      // Single pass
      bus.out_ready_i     = 1'b1;
      bus.in_valid_i      = 1'b1;
      bus.in_trans_id_i   = 3'd3;
      bus.in_result_i     = 64'hDEAD_BEEF_0000_0001;
      bus.in_branch_res_i = 1'b1;
`ifdef ALU_RESULT_BUFFER_BYPASS_EN
      #1;
      chk("sp_byp_valid", 64'(bus.out_valid_o), 64'd1);
      chk("sp_byp_id", 64'(bus.out_trans_id_o), 64'd3);
      chk("sp_byp_result", bus.out_result_o, 64'hDEAD_BEEF_0000_0001);
      cyc();
      bus.in_valid_i = 1'b0;
      chk("sp_byp_count", 64'(bus.count_o), 64'd0);
`else
      cyc();
      bus.in_valid_i = 1'b0;
      chk("sp_valid", 64'(bus.out_valid_o), 64'd1);
      chk("sp_id", 64'(bus.out_trans_id_o), 64'd3);
      chk("sp_result", bus.out_result_o, 64'hDEAD_BEEF_0000_0001);
      chk("sp_br", 64'(bus.out_branch_res_o), 64'd1);
      cyc();
      chk("sp_count_after", 64'(bus.count_o), 64'd0);
`endif

      // Fill and stall
      bus.out_ready_i = 1'b0;
      push_one(3'd1, 64'h11, 1'b0);
      push_one(3'd2, 64'h22, 1'b1);
      chk("fill_count", 64'(bus.count_o), 64'd2);
      chk("fill_in_ready", 64'(bus.in_ready_o), 64'd0);
      push_one(3'd7, 64'h77, 1'b1);
      chk("fill_ignored_count", 64'(bus.count_o), 64'd2);
      chk("fill_head_id", 64'(bus.out_trans_id_o), 64'd1);
      bus.out_ready_i = 1'b1;
      cyc();
      chk("drain1_id", 64'(bus.out_trans_id_o), 64'd2);
      chk("drain1_in_ready", 64'(bus.in_ready_o), 64'd1);
      cyc();
      chk("drain2_count", 64'(bus.count_o), 64'd0);

      // Wrap-around: ten pushes with random backpressure, order recorded at the output
      sent = 0;
      for (int c = 0; c < 200 && sent < 10; c++) begin
         bus.out_ready_i     = 1'($urandom_range(0, 1));
         bus.in_valid_i      = 1'b1;
         bus.in_trans_id_i   = TIDW'(sent % 8);
         bus.in_result_i     = {$urandom, $urandom};
         bus.in_branch_res_i = 1'($urandom);
         will_accept         = bus.in_ready_o;
         #1;
         if (bus.out_valid_o && bus.out_ready_i) popped.push_back(bus.out_trans_id_o);
         cyc();
         if (will_accept) sent++;
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      chk("wrap_sent", 64'(sent), 64'd10);
      for (int c = 0; c < 4; c++) begin
         #1;
         if (bus.out_valid_o) popped.push_back(bus.out_trans_id_o);
         cyc();
      end
      chk("wrap_pop_count", 64'(popped.size()), 64'd10);
      for (int i = 0; i < popped.size() && i < 10; i++)
         chk("wrap_order", 64'(popped[i]), 64'(i % 8));

      // Flush with simultaneous push and pop
      bus.out_ready_i = 1'b0;
      push_one(3'd4, 64'h44, 1'b0);
      bus.flush_i       = 1'b1;
      bus.in_valid_i    = 1'b1;
      bus.in_trans_id_i = 3'd6;
      bus.out_ready_i   = 1'b1;
      cyc();
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("flush_count", 64'(bus.count_o), 64'd0);
      chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
      repeat (2) cyc();
      chk("flush_no_ghost", 64'(bus.out_valid_o), 64'd0);

      // Reset mid-stream
      bus.out_ready_i = 1'b0;
      push_one(3'd1, 64'hA1, 1'b1);
      push_one(3'd2, 64'hA2, 1'b0);
      chk("mid_count_pre", 64'(bus.count_o), 64'd2);
      rst_ni = 1'b0;
      cyc();
      rst_ni = 1'b1;
      chk("mid_count", 64'(bus.count_o), 64'd0);
      chk("mid_valid", 64'(bus.out_valid_o), 64'd0);
      chk("mid_result", bus.out_result_o, 64'd0);
      push_one(3'd5, 64'h55, 1'b1);
      chk("mid_push_count", 64'(bus.count_o), 64'd1);
      chk("mid_push_id", 64'(bus.out_trans_id_o), 64'd5);
      bus.out_ready_i = 1'b1;
      cyc();
      chk("mid_empty", 64'(bus.out_valid_o), 64'd0);

      // Random traffic with occasional flushes
      for (int c = 0; c < 400; c++) begin
         bus.in_valid_i      = 1'($urandom_range(0, 1));
         bus.out_ready_i     = 1'($urandom_range(0, 1));
         bus.flush_i         = ($urandom_range(0, 11) == 0);
         bus.in_trans_id_i   = TIDW'($urandom);
         bus.in_result_i     = {$urandom, $urandom};
         bus.in_branch_res_i = 1'($urandom);
         cyc();
      end
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Registered result FIFO sitting directly downstream of the integer ALU, between ALU output and the writeback/commit arbitration port.
- Captures each ALU result together with its branch-compare bit and scoreboard transaction ID.
- Holds results while writeback is stalled by other functional units.
- Supports a pipeline flush that discards speculative entries.

Parameters:
- XLEN, 64, result datapath width (32 or 64).
- TRANS_ID_BITS, 3, scoreboard transaction ID width.
- DEPTH, 2, entry count; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard all entries and any same-cycle push.
- in_valid_i  in  1  ALU result valid.
- in_ready_o  out  1  buffer can accept (= not full).
- in_trans_id_i  in  TRANS_ID_BITS  scoreboard ID of result.
- in_result_i  in  XLEN  ALU result.
- in_branch_res_i  in  1  ALU branch-compare result.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  writeback accepts head.
- out_trans_id_o  out  TRANS_ID_BITS  head ID.
- out_result_o  out  XLEN  head result.
- out_branch_res_o  out  1  head branch bit.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: sampled only on a rising clk_i edge with rst_ni=0.
  - Pointers and count go to 0.
  - out_valid_o=0, in_ready_o=1, count_o=0.
  - Data outputs are 0 (storage is cleared on reset).
- Push: in_valid_i && in_ready_o && !flush_i writes the entry at the write pointer.
  - Entry is visible at the outputs no earlier than the next cycle (1-cycle latency without the optional feature).
- Pop: out_valid_o && out_ready_i && !flush_i advances the read pointer.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally.
  - count = count + push − pop.
  - Full when count==DEPTH; empty when count==0.
- in_ready_o = (count != DEPTH); purely registered state, no combinational dependence on out_ready_i.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Push and pop with count==0: impossible without the optional feature (out_valid_o=0).
- Outputs driven combinationally from the head entry; out_valid_o = (count != 0).
- Output stability: while out_valid_o && !out_ready_i && !flush_i, the out_* data must hold stable until popped.
- Input sampling: in_* values are sampled only when the push fires; values while in_ready_o=0 are ignored.
- flush_i=1: next cycle count=0 and both pointers reset to 0.
  - Any push or pop in that cycle is ignored.
  - out_valid_o=0 from the next cycle.
  - flush_i has priority over everything except reset.
- Reset asserted mid-operation: identical to the reset state; contents lost.
- Assertions (simulation only):
  - No push when full.
  - count never exceeds DEPTH.
  - out_* stable while stalled.

Optional Feature:
- Macro: ALU_RESULT_BUFFER_BYPASS_EN.
- Defined:
  - When count==0, in_valid_i=1 and !flush_i, the outputs combinationally present in_* with out_valid_o=1.
  - If out_ready_i=1 in that cycle, the result is consumed with 0-cycle latency, not written, and count stays 0.
  - If out_ready_i=0, it is written normally.
  - in_ready_o is unchanged (not full).
- Undefined: no combinational in→out path; minimum latency is 1 cycle; out_valid_o depends only on registered state.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles → out_valid_o=0, in_ready_o=1, count_o=0, out_result_o=0.
- Single pass: push id=3, result=0xDEAD_BEEF_0000_0001, branch=1 with out_ready_i=1.
  - Without bypass: out_valid_o=1 next cycle with the same fields, popped, count returns to 0.
  - With bypass: same data visible in the push cycle.
- Fill and stall (DEPTH=2): out_ready_i=0, push ids 1 and 2 → count_o=2, in_ready_o=0; third in_valid_i is ignored.
  - Then out_ready_i=1 → ids 1 then 2 pop in order, in_ready_o=1 after the first pop.
- Wrap-around: 10 back-to-back pushes, ids 0..7 cyclic, with random out_ready_i → output order equals input order, no loss or duplication, count_o matches a reference model every cycle.
- Flush with push+pop: count=1, assert flush_i together with in_valid_i and out_ready_i → next cycle count_o=0, out_valid_o=0, and the pushed entry never appears.
- Reset mid-stream: count=2, pulse rst_ni=0 for one edge → count_o=0, out_valid_o=0; a subsequent push id=5 emerges as the only entry.
